// File: rtl/rob_pkg.sv
// Shared definitions for the reorder buffer: default geometry, opcode
// classes for control-flow instructions and the default-width entry layout.
package rob_pkg;

  localparam int ROB_W_DEF = 4;
  localparam int XLEN_DEF  = 32;
  localparam int OP_W_DEF  = 6;
  localparam int REG_W_DEF = 5;

  // Control-flow opcode classes (6-bit major opcode encoding).
  localparam logic [OP_W_DEF-1:0] OPC_BRANCH = 6'h18;
  localparam logic [OP_W_DEF-1:0] OPC_JALR   = 6'h19;
  localparam logic [OP_W_DEF-1:0] OPC_JAL    = 6'h1B;

  // Number of entries for a given log2 size.
  function automatic int rob_depth(input int rob_w);
    return 1 << rob_w;
  endfunction

  localparam int DEPTH_DEF = rob_depth(ROB_W_DEF);

  // One in-flight instruction at the default widths.
  typedef struct packed {
    logic [OP_W_DEF-1:0]  opcode;
    logic [REG_W_DEF-1:0] rd;
    logic [XLEN_DEF-1:0]  pc;
    logic [XLEN_DEF-1:0]  val;
    logic [XLEN_DEF-1:0]  target;
    logic                 rdy;
    logic                 is_br;
    logic                 pred;
    logic                 taken;
  } rob_entry_t;

endpackage

// File: rtl/rob_param_if.sv
// Dispatcher / CDB / commit bundle of the reorder buffer. The master side
// (dispatcher, CDB, bench) drives issue, writeback and queries; the slave
// side is the ROB itself.
interface rob_param_if #(
  parameter int ROB_W = 4,
  parameter int XLEN  = 32,
  parameter int OP_W  = 6,
  parameter int REG_W = 5
);
  logic             rdy;
  logic             issue_en;
  logic [OP_W-1:0]  issue_opcode;
  logic [REG_W-1:0] issue_rd;
  logic [XLEN-1:0]  issue_pc;
  logic             issue_is_br;
  logic             issue_pred_taken;
  logic [ROB_W-1:0] free_rob_id;
  logic             is_full;
  logic             wb_en;
  logic [ROB_W-1:0] wb_id;
  logic [XLEN-1:0]  wb_val;
  logic             wb_taken;
  logic [XLEN-1:0]  wb_target;
  logic [ROB_W-1:0] qry_id1;
  logic [ROB_W-1:0] qry_id2;
  logic             qry_rdy1;
  logic             qry_rdy2;
  logic [XLEN-1:0]  qry_val1;
  logic [XLEN-1:0]  qry_val2;
  logic             commit_en;
  logic [ROB_W-1:0] commit_id;
  logic [REG_W-1:0] commit_rd;
  logic [XLEN-1:0]  commit_val;
  logic             clear_to_insFetch;
  logic [XLEN-1:0]  new_pc;
  logic             pre_upt_en;
  logic [XLEN-1:0]  pre_upt_pc;
  logic             is_jump;

  modport master (
    output rdy, issue_en, issue_opcode, issue_rd, issue_pc, issue_is_br,
           issue_pred_taken, wb_en, wb_id, wb_val, wb_taken, wb_target,
           qry_id1, qry_id2,
    input  free_rob_id, is_full, qry_rdy1, qry_rdy2, qry_val1, qry_val2,
           commit_en, commit_id, commit_rd, commit_val, clear_to_insFetch,
           new_pc, pre_upt_en, pre_upt_pc, is_jump
  );

  modport slave (
    input  rdy, issue_en, issue_opcode, issue_rd, issue_pc, issue_is_br,
           issue_pred_taken, wb_en, wb_id, wb_val, wb_taken, wb_target,
           qry_id1, qry_id2,
    output free_rob_id, is_full, qry_rdy1, qry_rdy2, qry_val1, qry_val2,
           commit_en, commit_id, commit_rd, commit_val, clear_to_insFetch,
           new_pc, pre_upt_en, pre_upt_pc, is_jump
  );
endinterface

// File: rtl/rob_ptr.sv
// Wrap-around queue pointer. A clear loads an explicit value (used by the
// flush to realign head and tail); otherwise inc advances modulo 2**W.
module rob_ptr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         clr_i,
  input  logic [W-1:0] clr_val_i,
  output logic [W-1:0] ptr_o
);
  logic [W-1:0] ptr_q, ptr_d;

  // Next pointer: clear has priority over increment.
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i)      ptr_d = clr_val_i;
    else if (inc_i) ptr_d = ptr_q + W'(1);
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;
endmodule

// File: rtl/rob_param.sv
// Parametrised reorder buffer: in-order allocate, out-of-order writeback,
// in-order registered commit with branch resolution and flush at commit.
module rob_param
  import rob_pkg::*;
#(
  parameter int ROB_W = ROB_W_DEF,
  parameter int XLEN  = XLEN_DEF,
  parameter int OP_W  = OP_W_DEF,
  parameter int REG_W = REG_W_DEF
) (
  input logic       clk,
  input logic       rst,
  rob_param_if.slave bus
);
  localparam int DEPTH = rob_depth(ROB_W);
  localparam logic [ROB_W:0] CNT_FULL = (ROB_W+1)'(DEPTH);
  localparam logic [ROB_W:0] CNT_ONE  = (ROB_W+1)'(1);

  // Entry payload at this instance's widths; the ready bits live in a
  // separate vector so a flush can clear them all at once.
  typedef struct packed {
    logic [OP_W-1:0]  opcode;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  val;
    logic [XLEN-1:0]  target;
    logic             is_br;
    logic             pred;
    logic             taken;
  } entry_t;

  entry_t           ent_q [DEPTH];
  logic [DEPTH-1:0] rdy_q;
  logic [ROB_W:0]   count_q, count_d;
  logic [ROB_W-1:0] head, tail, head_nxt, wb_off;
  entry_t           head_ent;
  logic             full, commit_fire, mispredict, alloc_fire, wb_fire, wb_alloc;

  logic             commit_en_q, clear_q, pre_upt_en_q, is_jump_q;
  logic [ROB_W-1:0] commit_id_q;
  logic [REG_W-1:0] commit_rd_q;
  logic [XLEN-1:0]  commit_val_q, new_pc_q, pre_upt_pc_q;

  assign head_ent = ent_q[head];
  assign head_nxt = head + ROB_W'(1);
  assign full     = (count_q == CNT_FULL);
  assign wb_off   = bus.wb_id - head;
  assign wb_alloc = ({1'b0, wb_off} < count_q);

  // Commit uses only the registered ready bit, so a writeback is never
  // retired on its own edge. An issue is accepted while full only when the
  // head retires on the same edge; nothing is accepted on a flush edge or
  // during the clear cycle.
  assign commit_fire = bus.rdy & (count_q != '0) & rdy_q[head];
  assign mispredict  = commit_fire & head_ent.is_br & (head_ent.taken != head_ent.pred);
  assign alloc_fire  = bus.rdy & bus.issue_en & (~full | commit_fire) & ~clear_q & ~mispredict;
  assign wb_fire     = bus.rdy & bus.wb_en & wb_alloc & ~clear_q & ~mispredict;

  // Head and tail both land on the slot after the mispredicted branch.
  rob_ptr #(.W(ROB_W)) u_head (
    .clk(clk), .rst(rst), .inc_i(commit_fire), .clr_i(mispredict),
    .clr_val_i(head_nxt), .ptr_o(head)
  );
  rob_ptr #(.W(ROB_W)) u_tail (
    .clk(clk), .rst(rst), .inc_i(alloc_fire), .clr_i(mispredict),
    .clr_val_i(head_nxt), .ptr_o(tail)
  );

  // Occupancy: simultaneous issue and commit leaves the count unchanged.
  always_comb begin
    count_d = count_q;
    if (mispredict)                     count_d = '0;
    else if (alloc_fire && !commit_fire) count_d = count_q + CNT_ONE;
    else if (commit_fire && !alloc_fire) count_d = count_q - CNT_ONE;
  end

  // Occupancy register.
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  // Entry payload writes; no reset needed since ready bits gate every use.
  always_ff @(posedge clk) begin
    if (wb_fire) begin
      ent_q[bus.wb_id].val    <= bus.wb_val;
      ent_q[bus.wb_id].taken  <= bus.wb_taken;
      ent_q[bus.wb_id].target <= bus.wb_target;
    end
    if (alloc_fire) begin
      ent_q[tail].opcode <= bus.issue_opcode;
      ent_q[tail].rd     <= bus.issue_rd;
      ent_q[tail].pc     <= bus.issue_pc;
      ent_q[tail].is_br  <= bus.issue_is_br;
      ent_q[tail].pred   <= bus.issue_pred_taken;
    end
  end

  // Ready bits: flush wipes all; a fresh allocation overrides a same-edge wb.
  always_ff @(posedge clk) begin
    if (rst || mispredict) begin
      rdy_q <= '0;
    end else begin
      if (wb_fire)    rdy_q[bus.wb_id] <= 1'b1;
      if (alloc_fire) rdy_q[tail]      <= 1'b0;
    end
  end

  // Registered commit, predictor-update and redirect outputs; all hold while rdy is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      commit_en_q  <= 1'b0;
      commit_id_q  <= '0;
      commit_rd_q  <= '0;
      commit_val_q <= '0;
      clear_q      <= 1'b0;
      new_pc_q     <= '0;
      pre_upt_en_q <= 1'b0;
      pre_upt_pc_q <= '0;
      is_jump_q    <= 1'b0;
    end else if (bus.rdy) begin
      commit_en_q  <= commit_fire;
      clear_q      <= mispredict;
      pre_upt_en_q <= commit_fire & head_ent.is_br;
      if (commit_fire) begin
        commit_id_q  <= head;
        commit_rd_q  <= head_ent.rd;
        commit_val_q <= head_ent.val;
        if (head_ent.is_br) begin
          pre_upt_pc_q <= head_ent.pc;
          is_jump_q    <= head_ent.taken;
        end
      end
      if (mispredict) new_pc_q <= head_ent.taken ? head_ent.target : head_ent.pc + XLEN'(4);
    end
  end

  // Operand lookup with same-cycle CDB bypass.
  always_comb begin
    bus.qry_rdy1 = rdy_q[bus.qry_id1];
    bus.qry_val1 = ent_q[bus.qry_id1].val;
    bus.qry_rdy2 = rdy_q[bus.qry_id2];
    bus.qry_val2 = ent_q[bus.qry_id2].val;
    if (bus.wb_en && bus.wb_id == bus.qry_id1) begin
      bus.qry_rdy1 = 1'b1;
      bus.qry_val1 = bus.wb_val;
    end
    if (bus.wb_en && bus.wb_id == bus.qry_id2) begin
      bus.qry_rdy2 = 1'b1;
      bus.qry_val2 = bus.wb_val;
    end
  end

  assign bus.free_rob_id       = tail;
  assign bus.is_full           = full;
  assign bus.commit_en         = commit_en_q;
  assign bus.commit_id         = commit_id_q;
  assign bus.commit_rd         = commit_rd_q;
  assign bus.commit_val        = commit_val_q;
  assign bus.clear_to_insFetch = clear_q;
  assign bus.new_pc            = new_pc_q;
  assign bus.pre_upt_en        = pre_upt_en_q;
  assign bus.pre_upt_pc        = pre_upt_pc_q;
  assign bus.is_jump           = is_jump_q;
endmodule

// File: tb/tb_rob_param.sv
// Directed bench for rob_param: in-order commit, full/wrap, mispredict
// flush, query bypass, rdy freeze and reset during a clear cycle.
module tb_rob_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rob_param_if #(.ROB_W(4), .XLEN(32), .OP_W(6), .REG_W(5)) bus ();

  rob_param #(.ROB_W(4), .XLEN(32), .OP_W(6), .REG_W(5)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int total = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_issue(input logic [4:0] rd, input logic [31:0] pc,
                          input logic is_br, input logic pred);
    bus.issue_en = 1'b1;
    bus.issue_opcode = is_br ? 6'h18 : 6'h0C;
    bus.issue_rd = rd;
    bus.issue_pc = pc;
    bus.issue_is_br = is_br;
    bus.issue_pred_taken = pred;
    cyc();
    bus.issue_en = 1'b0;
    $display("issue rd=%0d pc=0x%0h br=%0b pred=%0b -> free_rob_id=%0d full=%0b",
             rd, pc, is_br, pred, bus.free_rob_id, bus.is_full);
  endtask

  task automatic do_wb(input logic [3:0] id, input logic [31:0] val,
                       input logic taken, input logic [31:0] tgt);
    bus.wb_en = 1'b1;
    bus.wb_id = id;
    bus.wb_val = val;
    bus.wb_taken = taken;
    bus.wb_target = tgt;
    cyc();
    bus.wb_en = 1'b0;
    $display("wb id=%0d val=0x%0h taken=%0b target=0x%0h", id, val, taken, tgt);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    bus.rdy = 1'b1;
    bus.issue_en = 1'b0; bus.issue_opcode = '0; bus.issue_rd = '0; bus.issue_pc = '0;
    bus.issue_is_br = 1'b0; bus.issue_pred_taken = 1'b0;
    bus.wb_en = 1'b0; bus.wb_id = '0; bus.wb_val = '0; bus.wb_taken = 1'b0; bus.wb_target = '0;
    bus.qry_id1 = '0; bus.qry_id2 = '0;

    // Reset state
    do_reset();
    check("rst_commit_en", bus.commit_en, 0);
    check("rst_clear", bus.clear_to_insFetch, 0);
    check("rst_pre_upt", bus.pre_upt_en, 0);
    check("rst_new_pc", bus.new_pc, 0);
    check("rst_full", bus.is_full, 0);
    check("rst_free_id", bus.free_rob_id, 0);

    // In-order commit of out-of-order writebacks
    do_issue(5'd1, 32'h1000, 1'b0, 1'b0);
    do_issue(5'd2, 32'h1004, 1'b0, 1'b0);
    do_issue(5'd3, 32'h1008, 1'b0, 1'b0);
    check("free_after3", bus.free_rob_id, 3);
    do_wb(4'd2, 32'h22, 1'b0, 32'h0);
    check("no_commit_head_busy", bus.commit_en, 0);
    do_wb(4'd0, 32'h00, 1'b0, 32'h0);
    check("no_commit_same_edge", bus.commit_en, 0);
    do_wb(4'd1, 32'h11, 1'b0, 32'h0);
    check("c0_en", bus.commit_en, 1);
    check("c0_id", bus.commit_id, 0);
    check("c0_rd", bus.commit_rd, 1);
    check("c0_val", bus.commit_val, 32'h00);
    cyc();
    check("c1_id", bus.commit_id, 1);
    check("c1_rd", bus.commit_rd, 2);
    check("c1_val", bus.commit_val, 32'h11);
    cyc();
    check("c2_en", bus.commit_en, 1);
    check("c2_id", bus.commit_id, 2);
    check("c2_rd", bus.commit_rd, 3);
    check("c2_val", bus.commit_val, 32'h22);
    cyc();
    check("c_done", bus.commit_en, 0);
    $display("in-order commit sequence done");

    // Full, ignored issue, issue+commit on one edge with wrap
    do_reset();
    for (int i = 0; i < 16; i++) do_issue(5'(i + 1), 32'h2000 + 32'(4 * i), 1'b0, 1'b0);
    check("full16", bus.is_full, 1);
    check("wrap_free0", bus.free_rob_id, 0);
    do_issue(5'd20, 32'h3000, 1'b0, 1'b0);
    check("ovf_free", bus.free_rob_id, 0);
    check("ovf_full", bus.is_full, 1);
    check("ovf_no_commit", bus.commit_en, 0);
    do_wb(4'd0, 32'h55, 1'b0, 32'h0);
    check("full_wb_nocommit", bus.commit_en, 0);
    do_issue(5'd9, 32'h3004, 1'b0, 1'b0);
    check("ic_commit_en", bus.commit_en, 1);
    check("ic_commit_id", bus.commit_id, 0);
    check("ic_commit_val", bus.commit_val, 32'h55);
    check("ic_full", bus.is_full, 1);
    check("ic_free", bus.free_rob_id, 1);
    cyc();
    check("ic_after_en", bus.commit_en, 0);
    check("ic_after_full", bus.is_full, 1);

    // Mispredicted (not-taken predicted, taken actual) branch with 4 younger
    do_reset();
    do_issue(5'd0, 32'h100, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) do_issue(5'(i + 4), 32'h104 + 32'(4 * i), 1'b0, 1'b0);
    check("br_free5", bus.free_rob_id, 5);
    do_wb(4'd1, 32'h33, 1'b0, 32'h0);
    do_wb(4'd0, 32'h0, 1'b1, 32'h200);
    bus.issue_en = 1'b1; bus.issue_is_br = 1'b0; bus.issue_rd = 5'd9; bus.issue_pc = 32'h500;
    cyc();
    check("mp_commit_en", bus.commit_en, 1);
    check("mp_commit_id", bus.commit_id, 0);
    check("mp_clear", bus.clear_to_insFetch, 1);
    check("mp_new_pc", bus.new_pc, 32'h200);
    check("mp_pre_upt", bus.pre_upt_en, 1);
    check("mp_pre_pc", bus.pre_upt_pc, 32'h100);
    check("mp_is_jump", bus.is_jump, 1);
    check("mp_free", bus.free_rob_id, 1);
    bus.wb_en = 1'b1; bus.wb_id = 4'd1; bus.wb_val = 32'h66;
    cyc();
    bus.issue_en = 1'b0; bus.wb_en = 1'b0;
    check("clr_cyc_clear", bus.clear_to_insFetch, 0);
    check("clr_cyc_commit", bus.commit_en, 0);
    check("clr_cyc_pre", bus.pre_upt_en, 0);
    check("clr_cyc_free", bus.free_rob_id, 1);
    check("clr_cyc_full", bus.is_full, 0);
    cyc();
    check("flush_no_commit", bus.commit_en, 0);
    $display("taken mispredict flush done");

    // Mispredict taken->not-taken, then a correct prediction
    do_issue(5'd5, 32'h40, 1'b1, 1'b1);
    do_wb(4'd1, 32'h0, 1'b0, 32'h80);
    cyc();
    check("nt_commit_id", bus.commit_id, 1);
    check("nt_clear", bus.clear_to_insFetch, 1);
    check("nt_new_pc", bus.new_pc, 32'h44);
    check("nt_is_jump", bus.is_jump, 0);
    check("nt_pre_pc", bus.pre_upt_pc, 32'h40);
    cyc();
    do_issue(5'd6, 32'h60, 1'b1, 1'b1);
    do_wb(4'd2, 32'h0, 1'b1, 32'h300);
    cyc();
    check("ok_commit_id", bus.commit_id, 2);
    check("ok_pre_upt", bus.pre_upt_en, 1);
    check("ok_clear", bus.clear_to_insFetch, 0);
    check("ok_is_jump", bus.is_jump, 1);
    check("ok_pre_pc", bus.pre_upt_pc, 32'h60);
    check("ok_new_pc_hold", bus.new_pc, 32'h44);
    cyc();
    check("ok_pulse_drop", bus.pre_upt_en, 0);

    // Query bypass
    bus.qry_id1 = 4'd5; bus.qry_id2 = 4'd6;
    bus.wb_en = 1'b1; bus.wb_id = 4'd5; bus.wb_val = 32'hDEAD;
    #1;
    check("qry_byp_rdy", bus.qry_rdy1, 1);
    check("qry_byp_val", bus.qry_val1, 32'hDEAD);
    check("qry2_not_rdy", bus.qry_rdy2, 0);
    bus.wb_en = 1'b0;
    #1;
    check("qry_nobyp_rdy", bus.qry_rdy1, 0);
    $display("query bypass id5 rdy=%0b", bus.qry_rdy1);

    // rdy low freezes state and holds pulses
    do_issue(5'd7, 32'h500, 1'b0, 1'b0);
    do_issue(5'd8, 32'h504, 1'b0, 1'b0);
    do_wb(4'd3, 32'h77, 1'b0, 32'h0);
    cyc();
    check("pre_frz_commit", bus.commit_en, 1);
    check("pre_frz_val", bus.commit_val, 32'h77);
    bus.rdy = 1'b0;
    bus.issue_en = 1'b1; bus.issue_rd = 5'd9; bus.issue_pc = 32'h508; bus.issue_is_br = 1'b0;
    bus.wb_en = 1'b1; bus.wb_id = 4'd4; bus.wb_val = 32'h88;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("frz_commit_hold", bus.commit_en, 1);
      check("frz_commit_id", bus.commit_id, 3);
      check("frz_free", bus.free_rob_id, 5);
    end
    bus.issue_en = 1'b0; bus.wb_en = 1'b0; bus.qry_id2 = 4'd4;
    #1;
    check("frz_no_wb", bus.qry_rdy2, 0);
    bus.rdy = 1'b1;
    cyc();
    check("thaw_commit", bus.commit_en, 0);
    check("thaw_free", bus.free_rob_id, 5);
    $display("rdy freeze done");

    // Reset during the clear cycle
    do_reset();
    do_issue(5'd1, 32'h900, 1'b1, 1'b0);
    do_wb(4'd0, 32'h0, 1'b1, 32'hA00);
    cyc();
    check("rc_clear", bus.clear_to_insFetch, 1);
    check("rc_new_pc", bus.new_pc, 32'hA00);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("rc_clear0", bus.clear_to_insFetch, 0);
    check("rc_commit0", bus.commit_en, 0);
    check("rc_pre0", bus.pre_upt_en, 0);
    check("rc_new_pc0", bus.new_pc, 0);
    check("rc_pre_pc0", bus.pre_upt_pc, 0);
    check("rc_jump0", bus.is_jump, 0);
    check("rc_free0", bus.free_rob_id, 0);
    check("rc_full0", bus.is_full, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/rob_param.md
Name: rob_param

Overview:
- Parametrised reorder buffer; the next generation of the core's ROB.
- Circular queue of in-flight instructions. Allocated in order by the dispatcher, completed out of order from the CDB, retired in order to the register file.
- Resolves branch/jump mispredictions at commit: flushes the buffer and redirects insFetch.
- Adds operand lookup for the dispatcher and predictor-update reporting.

Parameters:
- ROB_W, 4, log2 of entry count (DEPTH = 2**ROB_W).
- XLEN, 32, data/PC width.
- OP_W, 6, opcode width.
- REG_W, 5, architectural register index width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- rdy  in  1  global enable; low freezes all state, outputs hold.
- issue_en  in  1  allocate one entry this cycle.
- issue_opcode  in  OP_W  opcode of the issued instruction.
- issue_rd  in  REG_W  destination register (0 = none).
- issue_pc  in  XLEN  instruction PC.
- issue_is_br  in  1  entry is a branch/jump.
- issue_pred_taken  in  1  fetch-time prediction.
- free_rob_id  out  ROB_W  id the next issue will receive (= tail).
- is_full  out  1  count == DEPTH.
- wb_en  in  1  CDB result valid.
- wb_id  in  ROB_W  completing entry.
- wb_val  in  XLEN  result value.
- wb_taken  in  1  actual branch direction.
- wb_target  in  XLEN  actual taken target.
- qry_id1, qry_id2  in  ROB_W  dispatcher operand lookups.
- qry_rdy1, qry_rdy2  out  1  entry result available.
- qry_val1, qry_val2  out  XLEN  entry result.
- commit_en  out  1  one-cycle retire pulse.
- commit_id  out  ROB_W  retired id.
- commit_rd  out  REG_W  destination for the register file.
- commit_val  out  XLEN  value for the register file.
- clear_to_insFetch  out  1  one-cycle flush pulse to all units.
- new_pc  out  XLEN  redirect PC, valid with clear.
- pre_upt_en  out  1  predictor update pulse.
- pre_upt_pc  out  XLEN  PC of the resolved branch.
- is_jump  out  1  actual direction for the predictor update.

Behaviour:
- Reset:
  - head = tail = count = 0; all rdy bits cleared.
  - All registered outputs 0.
  - is_full = 0; free_rob_id = 0.
- Allocation (edge with rdy & issue_en & !is_full & !clear_to_insFetch):
  - Writes opcode/rd/pc/is_br/pred into entry[tail] and clears its rdy bit.
  - tail <= tail+1, wrapping modulo DEPTH.
  - issue_en while full is ignored; the dispatcher must check is_full.
- Writeback (edge with rdy & wb_en):
  - Sets rdy[wb_id] and stores val/taken/target.
  - wb to an unallocated id is ignored.
- Query (combinational): rdy/val from the entry, with bypass: if wb_en & wb_id == qry_id, return rdy = 1 and val = wb_val.
- Commit, at most one per cycle:
  - Registered: on an edge where count > 0 and rdy[head] (registered bit, no wb bypass), commit_en = 1 for the next cycle with entry fields; head++ and count-- on the same edge.
  - Minimum latency: wb at edge N -> commit_en high after edge N+1.
- Branch at commit (is_br set):
  - pre_upt_en = 1, pre_upt_pc = pc, is_jump = taken.
  - If taken != pred: clear_to_insFetch = 1 and new_pc = taken ? target : pc+4, in the same cycle as commit_en.
- Flush:
  - On the edge that raises clear, all younger entries are discarded: head = tail = head+1, count = 0, rdy bits cleared.
  - Issue and wb in that edge and in the clear cycle are ignored.
- Count rules:
  - Simultaneous issue and commit: count unchanged; full stays full.
  - count never exceeds DEPTH and never underflows.
- Pulses: commit_en, clear_to_insFetch and pre_upt_en are single-cycle; they return to 0 unless re-asserted.
- rdy low: no state change, pulse outputs hold their value; the consumer qualifies them with rdy.
- rst overrides everything, including mid-flush.

Decomposition:
- Package rob_pkg: opcode constants (branch/jump classes), entry record typedef (opcode, rd, pc, val, target, rdy, is_br, pred, taken), DEPTH derivation.
- One sub-module, rob_ptr:
  - Wrap-around pointer/counter with inc and clear inputs.
  - Instantiated for head and tail.
- Entry storage stays inline (register array).

Test Plan:
- Reset, then issue 3 entries (rd = 1,2,3), wb ids 2,0,1 with vals 0x22,0x00,0x11 -> commits in order id 0,1,2 with rd 1,2,3 and vals 0x00,0x11,0x22; commit_en never high two edges before its wb.
- Issue 16 entries (DEPTH = 16) -> is_full = 1, 17th issue_en ignored. Wb entry 0, then issue and commit on the same edge -> count stays 16, tail wraps to 0, free_rob_id = 1.
- Branch at pc 0x100, pred_taken = 0, wb taken = 1, target 0x200, with 4 younger entries -> clear = 1, new_pc = 0x200, pre_upt_en = 1, is_jump = 1. Next cycle count = 0 and no further commit.
- Branch pred_taken = 1, wb taken = 0 at pc 0x40 -> new_pc = 0x44. A correctly predicted branch -> pre_upt_en = 1, clear = 0.
- Query id 5 while wb_en with wb_id = 5, val 0xDEAD -> qry_rdy1 = 1, qry_val1 = 0xDEAD in the same cycle.
- Hold rdy = 0 for 3 cycles with issue_en/wb_en active -> no pointer or bit change. Assert rst during a clear cycle -> all outputs 0 next cycle.
